keypad_scanner_4x4: RTL and testbench
=====================================

Name: keypad_scanner_4x4

Overview:
- Input-side counterpart of the multiplexed 4-digit seven-segment driver: scans a 4x4 matrix keypad by rotating a one-hot column strobe and reading four row lines.
- Debounces whole-matrix frames, keeps a stable pressed-key map, and reports each new key press as a single event.
- Events use a valid/ack handshake so front-panel control logic can feed key codes to the hex display path.

Parameters:
- SCAN_DIV_W, 14: column dwell time is 2^SCAN_DIV_W clocks.
- DEBOUNCE_SCANS, 3: number of consecutive identical full frames required before the stable map updates. Legal range is 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  scan enable.
- rows  in  4  row sense lines, already synchronised externally, active-high (1 = key closed on driven column).
- cols  out  4  one-hot column strobe, active-high; cols[c] drives column c.
- pressed_map  out  16  debounced key state; bit index = row*4 + col.
- any_pressed  out  1  pressed_map != 0.
- multi_key  out  1  more than one bit of pressed_map set.
- key_valid  out  1  event pending.
- key_code  out  4  code of the pending event (row*4 + col); stable while key_valid=1.
- key_ack  in  1  consumer accepts the event; has effect only while key_valid=1.
- overrun  out  1  sticky flag: an event was dropped.

Behaviour:
- Reset (rst_n=0, async): all outputs are 0; the divider, column index, raw frame, previous frame and match counter are all 0.
- en=0:
  - cols=0; the divider and column index are held at 0; the raw frame and match counter are cleared.
  - pressed_map, key_valid, key_code and overrun hold their values.
  - The key_ack handshake still works.
- en=1: cols = one-hot of the column index (0001 -> 0010 -> 0100 -> 1000 -> 0001).
- Divider counts every enabled clock. A tick occurs when the divider reaches all-ones, then it wraps to 0.
- On a tick:
  - rows are sampled into raw frame bits {r*4 + col} for the current column, at the end of the dwell so the lines have settled.
  - The column index then advances, wrapping 3 -> 0.
- Frame complete means the tick on column 3. At that point the completed frame is compared with the previous frame:
  - Equal: the match counter increments, saturating at DEBOUNCE_SCANS.
  - Different: the match counter goes to 0.
  - In both cases the previous frame takes the new frame.
- Stable-map update:
  - When the match counter reaches DEBOUNCE_SCANS on a frame-complete tick and the frame differs from pressed_map, pressed_map loads the frame on that same edge.
  - Releases are debounced the same way but produce no event.
- New presses = new_map & ~old_map. If non-zero, the lowest set index is encoded into the event.
- Event register, evaluated on the edge that updates pressed_map:
  - key_valid=0: load key_code, set key_valid.
  - key_valid=1 and key_ack=1 in the same cycle: load the new code, key_valid stays 1.
  - key_valid=1 and key_ack=0: the event is dropped, key_code is unchanged, overrun is set.
- key_ack with key_valid=1 and no new event: key_valid clears next edge. key_ack also clears overrun, unless a drop happens in the same cycle; a drop wins.
- Other simultaneous presses within one frame: only the lowest index produces an event. The rest are visible in pressed_map.
- Latency: with a key held from the first enabled cycle, pressed_map and key_valid update on enabled edge 2^SCAN_DIV_W * 4 * (DEBOUNCE_SCANS+1).
- Deasserting en mid-frame discards the partial frame. Scanning restarts at column 0 with the match counter at 0.

Decomposition:
- Package keypad_pkg holds:
  - constants KEY_ROWS=4 and KEY_COLS=4;
  - typedef key_code_t (logic [3:0]);
  - typedef key_map_t (logic [15:0]);
  - function key_index(row, col).
- One combinational sub-module, key_priority_enc: 16-bit lowest-set-bit encoder producing key_code_t plus a found flag. It is reused for new-press detection.

Test Plan (SCAN_DIV_W=2, DEBOUNCE_SCANS=2, so 16 clocks per frame):
- Reset then en=1 with key (row1, col2) held -> cols visits 0001, 0010, 0100, 1000 in 4-clock steps; pressed_map=0x0040 and key_valid=1, key_code=6 after enabled edge 48; then key_ack -> key_valid=0 next edge.
- Key toggling every 10 clocks for 200 clocks, then held -> no event during toggling; exactly one event (code correct) 48 clocks after the last frame-aligned stable start.
- Keys 3 and 9 closed together -> pressed_map=0x0208, multi_key=1, key_code=3, single event.
- Event pending, no ack, second key pressed -> overrun=1, key_code unchanged; key_ack -> key_valid=0, overrun=0.
- key_ack asserted on the same edge a new press is latched -> key_valid stays 1 with the new code, overrun=0.
- en dropped for 5 clocks mid-frame, or rst_n pulsed mid-scan -> cols=0 immediately on reset; scanning restarts at column 0; debounce restarts (full 48-clock latency again).

Source files
------------

// File: rtl/keypad_scanner_4x4_pkg.sv
// Shared keypad types and helpers: matrix geometry, key code and key map types,
// and the row/column to key index mapping.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  typedef logic [3:0]  key_code_t;
  typedef logic [15:0] key_map_t;

  // Key index is row-major: row*4 + col.
  function automatic key_code_t key_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_4x4_priority_enc.sv
// Lowest-set-bit encoder over a 16-key map; returns the key code and a found flag.
module key_priority_enc
  import keypad_pkg::*;
(
  input  key_map_t  map_i,
  output key_code_t code_o,
  output logic      found_o
);

  // Descending loop so the lowest set index is the last assignment and wins.
  always_comb begin
    code_o  = '0;
    found_o = 1'b0;
    for (int i = KEY_ROWS*KEY_COLS-1; i >= 0; i--) begin
      if (map_i[i]) begin
        code_o  = key_code_t'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: rotating column strobe, whole-frame debounce,
// stable key map and single-event key press reporting with valid/ack.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 14,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [15:0] pressed_map,
  output logic        any_pressed,
  output logic        multi_key,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ack,
  output logic        overrun
);

  localparam logic [3:0] MATCH_MAX = 4'(DEBOUNCE_SCANS);

  logic [SCAN_DIV_W-1:0] div_q, div_d;
  logic [1:0]            col_q, col_d;
  key_map_t              raw_q, raw_d;
  key_map_t              prev_q, prev_d;
  key_map_t              map_q, map_d;
  logic [3:0]            match_q, match_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  key_code_t             code_q, code_d;

  logic       tick;
  logic       frame_done;
  logic       map_load;
  logic [3:0] match_nxt;
  key_map_t   frame;
  key_map_t   new_press;
  key_code_t  enc_code;
  logic       enc_found;

  assign tick       = en && (&div_q);
  assign frame_done = tick && (col_q == 2'd3);

  // Raw frame with the current column's rows merged in, as it would be after this tick.
  always_comb begin
    frame = raw_q;
    for (int r = 0; r < KEY_ROWS; r++) begin
      frame[key_index(2'(r), col_q)] = rows[r];
    end
  end

  always_comb begin
    if (frame == prev_q) begin
      match_nxt = (match_q == MATCH_MAX) ? match_q : match_q + 4'd1;
    end else begin
      match_nxt = 4'd0;
    end
  end

  assign map_load  = frame_done && (match_nxt == MATCH_MAX) && (frame != map_q);
  assign new_press = frame & ~map_q;

  key_priority_enc u_new_enc (
    .map_i   (new_press),
    .code_o  (enc_code),
    .found_o (enc_found)
  );

  always_comb begin
    div_d   = div_q;
    col_d   = col_q;
    raw_d   = raw_q;
    prev_d  = prev_q;
    match_d = match_q;
    map_d   = map_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    code_d  = code_q;

    if (!en) begin
      div_d   = '0;
      col_d   = 2'd0;
      raw_d   = '0;
      match_d = 4'd0;
    end else begin
      div_d = div_q + 1'b1;
      if (tick) begin
        raw_d = frame;
        col_d = col_q + 2'd1;
        if (frame_done) begin
          match_d = match_nxt;
          prev_d  = frame;
        end
      end
    end

    if (map_load) begin
      map_d = frame;
    end

    if (valid_q && key_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    // A drop can only happen with key_ack low, so it never races the ack clear.
    if (map_load && enc_found) begin
      if (!valid_q || key_ack) begin
        code_d  = enc_code;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      col_q   <= 2'd0;
      raw_q   <= '0;
      prev_q  <= '0;
      match_q <= 4'd0;
      map_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      raw_q   <= raw_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      map_q   <= map_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      code_q  <= code_d;
    end
  end

  // Gated by rst_n so the strobe drops the instant reset asserts, even with en high.
  assign cols        = (en && rst_n) ? (4'b0001 << col_q) : 4'b0000;
  assign pressed_map = map_q;
  assign any_pressed = |map_q;
  assign multi_key   = |(map_q & (map_q - 16'd1));
  assign key_valid   = valid_q;
  assign key_code    = code_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Bench for keypad_scanner_4x4 with a 16-clock frame: a keypad matrix model drives
// rows from cols, and expected key events are queued and matched as they appear.
module tb_keypad_scanner_4x4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] pressed_map;
  logic        any_pressed;
  logic        multi_key;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack;
  logic        overrun;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          e = 0;
  int          base;
  logic        mon_v = 1'b0;
  logic        mon_a = 1'b0;
  logic [3:0]  exp_code;

  keypad_scanner_4x4 #(.SCAN_DIV_W(2), .DEBOUNCE_SCANS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rows        (rows),
    .cols        (cols),
    .pressed_map (pressed_map),
    .any_pressed (any_pressed),
    .multi_key   (multi_key),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ack     (key_ack),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Closed key at (r,c) shorts column c onto row r.
  always_comb begin
    for (int r = 0; r < 4; r++) rows[r] = |(keys[r*4 +: 4] & cols);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic step_to(input int t);
    while (e < t) step(1);
  endtask

  task automatic align();
    while (e % 16 != 0) step(1);
  endtask

  task automatic wait_map(input logic [15:0] m, input int budget);
    int n;
    n = 0;
    while (pressed_map !== m && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_map", pressed_map, m);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    chk("ack_clears_valid", key_valid, 0);
  endtask

  // New event: valid rises, or valid stays high across an edge where ack was high.
  always @(negedge clk) begin
    if (key_valid && (!mon_v || mon_a)) begin
      chk("evq_has_item", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_code = exp_q.pop_front();
        chk("evt_code", key_code, exp_code);
      end
    end
    mon_v = key_valid;
    mon_a = key_ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    key_ack = 1'b0;
    keys    = 16'h0000;
    #3;
    chk("rst_cols", cols, 0);
    chk("rst_map", pressed_map, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_any", any_pressed, 0);
    repeat (2) @(posedge clk);
    #1;

    // Single key (row1,col2) held from the first enabled cycle.
    rst_n = 1'b1;
    en    = 1'b1;
    keys  = 16'h0040;
    exp_q.push_back(4'd6);
    e = 0;
    #1;
    chk("cols_c0", cols, 4'b0001);
    step_to(4);  chk("cols_c1", cols, 4'b0010);
    step_to(8);  chk("cols_c2", cols, 4'b0100);
    step_to(12); chk("cols_c3", cols, 4'b1000);
    step_to(16); chk("cols_wrap", cols, 4'b0001);
    step_to(47);
    chk("t1_map_early", pressed_map, 0);
    chk("t1_valid_early", key_valid, 0);
    step_to(48);
    chk("t1_map", pressed_map, 16'h0040);
    chk("t1_valid", key_valid, 1);
    chk("t1_code", key_code, 6);
    chk("t1_any", any_pressed, 1);
    chk("t1_multi", multi_key, 0);
    ack_pulse();

    // Bouncing key 14: no frame run long enough to debounce, then a clean press.
    keys = 16'h0000;
    wait_map(16'h0000, 200);
    align();
    for (int i = 0; i < 20; i++) begin
      keys = keys ^ 16'h4000;
      step(10);
    end
    keys = 16'h0000;
    chk("t2_no_evt_valid", key_valid, 0);
    chk("t2_no_evt_map", pressed_map, 0);
    step(32);
    align();
    keys = 16'h4000;
    exp_q.push_back(4'd14);
    base = e;
    step_to(base + 47);
    chk("t2_map_early", pressed_map, 0);
    step_to(base + 48);
    chk("t2_map", pressed_map, 16'h4000);
    chk("t2_code", key_code, 14);
    ack_pulse();

    // Keys 3 and 9 together: one event for the lower index.
    keys = 16'h0000;
    wait_map(16'h0000, 200);
    align();
    keys = 16'h0208;
    exp_q.push_back(4'd3);
    base = e;
    step_to(base + 47);
    chk("t3_map_early", pressed_map, 0);
    step_to(base + 48);
    chk("t3_map", pressed_map, 16'h0208);
    chk("t3_multi", multi_key, 1);
    chk("t3_code", key_code, 3);
    ack_pulse();

    // Pending event 5 not acked; press of key 10 is dropped.
    align();
    keys = keys | 16'h0020;
    exp_q.push_back(4'd5);
    base = e;
    step_to(base + 48);
    chk("t4_code5", key_code, 5);
    chk("t4_valid5", key_valid, 1);
    align();
    keys = keys | 16'h0400;
    base = e;
    step_to(base + 47);
    chk("t4_ovr_early", overrun, 0);
    step_to(base + 48);
    chk("t4_map", pressed_map, 16'h0628);
    chk("t4_ovr", overrun, 1);
    chk("t4_code_kept", key_code, 5);
    chk("t4_valid_kept", key_valid, 1);
    ack_pulse();
    chk("t4_ovr_clr", overrun, 0);

    // Ack coincides with the edge that latches the next press.
    align();
    keys = keys | 16'h0002;
    exp_q.push_back(4'd1);
    base = e;
    step_to(base + 48);
    chk("t5_code1", key_code, 1);
    keys = keys | 16'h8000;
    exp_q.push_back(4'd15);
    base = e;
    step_to(base + 47);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    chk("t5_valid_kept", key_valid, 1);
    chk("t5_code15", key_code, 15);
    chk("t5_ovr", overrun, 0);
    chk("t5_map", pressed_map, 16'h862A);
    ack_pulse();

    // en dropped mid-frame: partial frame discarded, full latency from re-enable.
    keys = 16'h0000;
    wait_map(16'h0000, 200);
    while (e % 16 != 6) step(1);
    keys = 16'h0080;
    exp_q.push_back(4'd7);
    step(2);
    en = 1'b0;
    step(1);
    chk("t6_cols_off", cols, 0);
    step(4);
    chk("t6_map_hold", pressed_map, 0);
    en = 1'b1;
    e = 0;
    #1;
    chk("t6_cols_restart", cols, 4'b0001);
    step_to(47);
    chk("t6_map_early", pressed_map, 0);
    step_to(48);
    chk("t6_map", pressed_map, 16'h0080);
    chk("t6_code", key_code, 7);
    ack_pulse();

    // Reset pulsed mid-scan with en high.
    step(7);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_cols", cols, 0);
    chk("t7_rst_map", pressed_map, 0);
    chk("t7_rst_valid", key_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(4'd7);
    e = 0;
    #1;
    chk("t7_cols_restart", cols, 4'b0001);
    step_to(47);
    chk("t7_map_early", pressed_map, 0);
    step_to(48);
    chk("t7_map", pressed_map, 16'h0080);
    chk("t7_valid", key_valid, 1);
    chk("t7_code", key_code, 7);
    ack_pulse();

    step(4);
    chk("evq_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
